// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and load/store.
// Data wins by default; a bounded streak counter guarantees fetch progress, and a wait counter bounds each access.
module mem_arbiter #(
    parameter int WIDTH        = 16,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_ack,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0]        STARVE_MAX  = 2'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [1:0]        streak_r, streak_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic              grant_d_s, timeout_s;
    logic              mem_req_s, mem_we_s, if_ack_s, d_ack_s, if_err_s, d_err_s;
    logic [WIDTH-1:0]  mem_addr_s, mem_wdata_s, if_rdata_s, d_rdata_s;

    // State register plus counters; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            streak_r <= 2'd0;
            wait_r   <= {WAIT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            streak_r <= streak_s;
            wait_r   <= wait_s;
        end
    end

    // Next-state: arbitration in IDLE, completion or timeout in BUSY, single-cycle RESP.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        grant_d_s = d_req && !(if_req && (streak_r == STARVE_MAX));
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_s = BUSY_D;
                end else if (if_req) begin
                    state_s = BUSY_IF;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack) begin
                    state_s = RESP;
                end else if (wait_r == WAIT_LAST) begin
                    state_s   = RESP;
                    timeout_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of every registered output, derived from the transition being taken.
    always_comb begin
        streak_s    = streak_r;
        wait_s      = wait_r;
        mem_we_s    = mem_we;
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        if_rdata_s  = if_rdata;
        d_rdata_s   = d_rdata;
        mem_req_s   = (state_s == BUSY_IF) || (state_s == BUSY_D);
        if_ack_s    = (state_r == BUSY_IF) && (state_s == RESP);
        d_ack_s     = (state_r == BUSY_D) && (state_s == RESP);
        if_err_s    = if_ack_s && timeout_s;
        d_err_s     = d_ack_s && timeout_s;
        case (state_r)
            IDLE: begin
                wait_s = {WAIT_W{1'b0}};
                if (state_s == BUSY_D) begin
                    mem_we_s    = d_we;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    if (if_req && (streak_r != STARVE_MAX)) begin
                        streak_s = streak_r + 2'd1;
                    end else begin
                        streak_s = streak_r;
                    end
                end else if (state_s == BUSY_IF) begin
                    mem_we_s   = 1'b0;
                    mem_addr_s = if_addr;
                    streak_s   = 2'd0;
                end else begin
                    streak_s = streak_r;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (state_s == RESP) begin
                    wait_s   = {WAIT_W{1'b0}};
                    mem_we_s = 1'b0;
                end else begin
                    wait_s = wait_r + WAIT_W'(1'b1);
                end
                // A timeout returns zero data to the winner only.
                if (state_s != RESP) begin
                    if_rdata_s = if_rdata;
                end else if (state_r == BUSY_IF) begin
                    if_rdata_s = mem_ack ? mem_rdata : {WIDTH{1'b0}};
                end else begin
                    d_rdata_s = mem_ack ? mem_rdata : {WIDTH{1'b0}};
                end
            end
            RESP:    wait_s = {WAIT_W{1'b0}};
            default: wait_s = {WAIT_W{1'b0}};
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {WIDTH{1'b0}};
            mem_wdata <= {WIDTH{1'b0}};
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= {WIDTH{1'b0}};
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= {WIDTH{1'b0}};
        end else begin
            mem_req   <= mem_req_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            if_ack    <= if_ack_s;
            if_err    <= if_err_s;
            if_rdata  <= if_rdata_s;
            d_ack     <= d_ack_s;
            d_err     <= d_err_s;
            d_rdata   <= d_rdata_s;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, address/data width in bits.
REQ-002 Parameter STARVE_LIMIT, default 3, max consecutive data grants while a fetch waits.
REQ-003 Parameter TIMEOUT, default 15, max cycles in a memory access waiting for mem_ack.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 if_req / if_addr  input  1 / WIDTH  instruction-fetch request and address.
REQ-007 if_ack / if_rdata / if_err  output  1 / WIDTH / 1  fetch completion pulse, read data, timeout flag.
REQ-008 d_req / d_we / d_addr / d_wdata  input  1 / 1 / WIDTH / WIDTH  load/store request, write enable, address, write data.
REQ-009 d_ack / d_rdata / d_err  output  1 / WIDTH / 1  load/store completion pulse, read data, timeout flag.
REQ-010 mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / WIDTH / WIDTH  shared single-port memory request.
REQ-011 mem_ack / mem_rdata  input  1 / WIDTH  memory completion strobe and read data.

Function
REQ-012 The block SHALL share one memory port between fetch and load/store, one transaction at a time; all outputs SHALL be registered.
REQ-013 States SHALL be IDLE, BUSY_IF, BUSY_D, RESP.
REQ-014 IDLE: no request -> stay; else pick a winner, latch its address/we/wdata, go to BUSY_IF or BUSY_D.
REQ-015 Priority: d_req SHALL win over if_req, except if_req SHALL win when streak == STARVE_LIMIT.
REQ-016 streak: 2-bit counter, saturating at STARVE_LIMIT; SHALL increment on a data grant made while if_req=1, hold on a data grant with if_req=0, clear on every fetch grant.
REQ-017 In BUSY_x, mem_req SHALL be 1, mem_addr/mem_we/mem_wdata SHALL show the latched values (mem_we=0 for fetch), and these SHALL stay stable until exit.
REQ-018 In BUSY_x, mem_ack=1 SHALL capture mem_rdata into the winner's rdata register and go to RESP.
REQ-019 In BUSY_x, a wait counter SHALL count cycles; when TIMEOUT cycles pass with no mem_ack, the block SHALL go to RESP with rdata=0 and the winner's err=1.
REQ-020 In RESP, mem_req SHALL be 0 and the winner's ack SHALL be 1 for exactly one cycle; err SHALL be valid in the same cycle; next state IDLE.
REQ-021 The loser's ack SHALL stay 0, and its rdata SHALL hold its previous value.
REQ-022 Latency: request sampled in IDLE at cycle 0 -> mem_req=1 in cycle 1 -> with mem_ack in cycle 1, ack in cycle 2 -> IDLE in cycle 3; minimum throughput is one transaction per 3 cycles.
REQ-023 Requesters SHALL hold req and operands until ack and drop req the cycle after ack; the arbiter SHALL ignore req/operand changes while not in IDLE.
REQ-024 If mem_ack is asserted outside BUSY_x, the block SHALL ignore it.
REQ-025 For writes, d_rdata SHALL be loaded with mem_rdata as presented (don't-care to the requester).

Reset
REQ-026 rst=1 SHALL force IDLE immediately, without waiting for clk, including mid-transaction.
REQ-027 rst=1 SHALL immediately set mem_req, mem_we, if_ack, d_ack, if_err, d_err to 0.
REQ-028 rst=1 SHALL immediately set mem_addr, mem_wdata, if_rdata, d_rdata, streak and the wait counter to 0.
REQ-029 After rst deasserts, the first grant SHALL follow the normal priority with streak=0.

Verification
REQ-030 Single fetch: if_req=1, if_addr=0x0010; memory acks in mem_req's first cycle with rdata=0xA5A5 -> if_ack pulses once in cycle 2, if_rdata=0xA5A5, if_err=0.
REQ-031 Simultaneous: if_req and d_req both 1 in IDLE (d_we=1, d_addr=0x0200, d_wdata=0x1234) -> data first with mem_we=1 and the given address/data, then the fetch; d_ack before if_ack.
REQ-032 Starvation: d_req held continuously with if_req=1 -> exactly 3 data grants, then 1 fetch grant, with streak reset to 0.
REQ-033 Timeout: d_req load, mem_ack held 0 -> d_ack=1, d_err=1, d_rdata=0 exactly after TIMEOUT=15 BUSY cycles; mem_req=0 in RESP.
REQ-034 Reset mid-access: rst pulsed in BUSY_IF between clock edges -> mem_req=0 before the next edge; no if_ack; a subsequent if_req completes normally.
REQ-035 Stray ack: mem_ack=1 in IDLE -> no ack outputs and no state change.
